// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths, forward-select encoding and scoreboard entry layout for hazard_scoreboard.
// REG_AW and T_W live here so the entry record has a single definition.
package hazard_scoreboard_pkg;

  localparam int REG_AW  = 5;
  localparam int T_W     = 2;
  localparam int FWD_GPR = 0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic [T_W-1:0]    tnew;
  } entry_t;

  // Tnew counts down to zero and then stays there until the entry retires.
  function automatic logic [T_W-1:0] tnewDec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_hzd_match.sv
// Youngest-match priority search of the scoreboard for one D-stage operand.
// Reports whether any entry matches, which entry (lowest index wins) and its remaining Tnew.
module hzd_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int SEL_W  = 2
) (
  input  entry_t [STAGES-1:0] entries_i,
  input  logic [REG_AW-1:0]   addr_i,
  input  logic                use_i,
  output logic                hit_o,
  output logic [SEL_W-1:0]    idx_o,
  output logic [T_W-1:0]      tnew_o
);

  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    tnew_o = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (use_i && (addr_i != '0) && entries_i[k].valid && (entries_i[k].dst == addr_i)) begin
        hit_o  = 1'b1;
        idx_o  = SEL_W'(k);
        tnew_o = entries_i[k].tnew;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: shift register of in-flight GPR writes driving D-stall and forward selects.
// Define HZD_MDU_EN to add md_busy/d_is_md and the mult/div structural stall.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic [T_W-1:0]    d_tuse_rs,
  input  logic [T_W-1:0]    d_tuse_rt,
  input  logic              d_wr,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [T_W-1:0]    d_tnew,
  input  logic              flush,
`ifdef HZD_MDU_EN
  input  logic              md_busy,
  input  logic              d_is_md,
`endif
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs,
  output logic [SEL_W-1:0]  fwd_rt
);

  entry_t [STAGES-1:0] entries_q, entries_d;

  logic             hitRs, hitRt;
  logic [SEL_W-1:0] idxRs, idxRt;
  logic [T_W-1:0]   tnewRs, tnewRt;
  logic             stallRs, stallRt;

  hzd_match #(.STAGES(STAGES), .SEL_W(SEL_W)) u_match_rs (
    .entries_i (entries_q),
    .addr_i    (d_rs),
    .use_i     (d_use_rs),
    .hit_o     (hitRs),
    .idx_o     (idxRs),
    .tnew_o    (tnewRs)
  );

  hzd_match #(.STAGES(STAGES), .SEL_W(SEL_W)) u_match_rt (
    .entries_i (entries_q),
    .addr_i    (d_rt),
    .use_i     (d_use_rt),
    .hit_o     (hitRt),
    .idx_o     (idxRt),
    .tnew_o    (tnewRt)
  );

  assign stallRs = hitRs && (tnewRs > d_tuse_rs);
  assign stallRt = hitRt && (tnewRt > d_tuse_rt);
  assign fwd_rs  = (hitRs && (tnewRs == '0)) ? idxRs + 1'b1 : SEL_W'(FWD_GPR);
  assign fwd_rt  = (hitRt && (tnewRt == '0)) ? idxRt + 1'b1 : SEL_W'(FWD_GPR);

`ifdef HZD_MDU_EN
  logic mdShadow_q, mdShadow_d;

  // The shadow remembers an md issued last cycle, before md_busy can reflect it.
  assign stall      = stallRs | stallRt | (d_is_md & (md_busy | mdShadow_q));
  assign mdShadow_d = d_is_md & ~stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mdShadow_q <= 1'b0;
    else          mdShadow_q <= mdShadow_d;
  end
`else
  assign stall = stallRs | stallRt;
`endif

  // A stalled, flushed or $0-writing instruction enters E as a bubble.
  always_comb begin
    entries_d          = '0;
    entries_d[0].valid = d_wr & ~stall & ~flush & (d_dst != '0);
    entries_d[0].dst   = d_dst;
    entries_d[0].tnew  = d_tnew;
    for (int k = 1; k < STAGES; k++) begin
      entries_d[k]      = entries_q[k-1];
      entries_d[k].tnew = tnewDec(entries_q[k-1].tnew);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) entries_q <= '0;
    else          entries_q <= entries_d;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus a modelled random run.
// Build with HZD_MDU_EN defined to exercise the mult/div stall as well.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
  logic       d_use_rs = 1'b0, d_use_rt = 1'b0, d_wr = 1'b0, flush = 1'b0;
  logic [1:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
  logic       stall;
  logic [1:0] fwd_rs, fwd_rt;
`ifdef HZD_MDU_EN
  logic       md_busy = 1'b0, d_is_md = 1'b0;
  bit         mShadow;
`endif

  int checks = 0;
  int errors = 0;
  logic [4:0] expQ[$];

  bit         mValid[3];
  logic [4:0] mDst[3];
  int         mTnew[3];

  hazard_scoreboard dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_use_rs  (d_use_rs),
    .d_use_rt  (d_use_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_wr      (d_wr),
    .d_dst     (d_dst),
    .d_tnew    (d_tnew),
    .flush     (flush),
`ifdef HZD_MDU_EN
    .md_busy   (md_busy),
    .d_is_md   (d_is_md),
`endif
    .stall     (stall),
    .fwd_rs    (fwd_rs),
    .fwd_rt    (fwd_rt)
  );

  always #5 clk = ~clk;

  // Reference: first (youngest) matching entry decides stall and forward source.
  function automatic void modelOp(input logic [4:0] r, input logic u, input logic [1:0] tu,
                                  output logic s, output logic [1:0] f);
    s = 1'b0;
    f = 2'd0;
    if (u && r != 5'd0) begin
      for (int k = 0; k < 3; k++) begin
        if (mValid[k] && mDst[k] == r) begin
          s = (mTnew[k] > int'(tu));
          f = (mTnew[k] == 0) ? 2'(k + 1) : 2'd0;
          return;
        end
      end
    end
  endfunction

  function automatic logic [4:0] modelEval();
    logic sr, st, md;
    logic [1:0] fr, ft;
    modelOp(d_rs, d_use_rs, d_tuse_rs, sr, fr);
    modelOp(d_rt, d_use_rt, d_tuse_rt, st, ft);
    md = 1'b0;
`ifdef HZD_MDU_EN
    md = d_is_md & (md_busy | mShadow);
`endif
    return {sr | st | md, fr, ft};
  endfunction

  task automatic modelClear();
    for (int k = 0; k < 3; k++) begin
      mValid[k] = 1'b0;
      mDst[k]   = '0;
      mTnew[k]  = 0;
    end
`ifdef HZD_MDU_EN
    mShadow = 1'b0;
`endif
  endtask

  task automatic present(input logic wr, input logic [4:0] dst, input logic [1:0] tnew,
                         input logic [4:0] rs, input logic urs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic urt, input logic [1:0] trt,
                         input logic fl);
    d_wr = wr; d_dst = dst; d_tnew = tnew;
    d_rs = rs; d_use_rs = urs; d_tuse_rs = trs;
    d_rt = rt; d_use_rt = urt; d_tuse_rt = trt;
    flush = fl;
  endtask

  task automatic sample(output logic [4:0] got, output logic [4:0] want);
    #2;
    got  = {stall, fwd_rs, fwd_rt};
    want = expQ.pop_front();
  endtask

  // Advance one clock, shifting the reference scoreboard alongside the DUT.
  task automatic tick();
    logic [4:0] e;
    e = modelEval();
    @(posedge clk);
    if (reset_n) begin
      for (int k = 2; k >= 1; k--) begin
        mValid[k] = mValid[k-1];
        mDst[k]   = mDst[k-1];
        mTnew[k]  = (mTnew[k-1] > 0) ? mTnew[k-1] - 1 : 0;
      end
      mValid[0] = d_wr & ~e[4] & ~flush & (d_dst != 5'd0);
      mDst[0]   = d_dst;
      mTnew[0]  = int'(d_tnew);
`ifdef HZD_MDU_EN
      mShadow = d_is_md & ~e[4];
`endif
    end
    @(negedge clk);
  endtask

  task automatic drain();
    logic [4:0] got, want;
    for (int i = 0; i < 3; i++) begin
      present(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expQ.push_back(5'b0);
      sample(got, want);
      checks++;
      if (got !== want) begin errors++; $display("[TB] FAIL drain got %b want %b", got, want); end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [4:0] got, want;
    modelClear();
    expQ.push_back(5'b0);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL reset_held got %b want %b", got, want); end
    @(negedge clk);
    reset_n = 1'b1;
    present(0, 0, 0, 5'd8, 1, 0, 5'd9, 1, 0, 0);
    expQ.push_back(5'b0);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL first_after_release got %b want %b", got, want); end
    tick();
    present(1, 5'd8, 2, 0, 0, 0, 0, 0, 0, 0); tick();
    present(1, 5'd9, 2, 0, 0, 0, 0, 0, 0, 0); tick();
    present(1, 5'd10, 2, 0, 0, 0, 0, 0, 0, 0); tick();
    present(0, 0, 0, 5'd8, 1, 0, 5'd9, 1, 0, 0);
    expQ.push_back(5'b1_11_00);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL three_entries got %b want %b", got, want); end
    reset_n = 1'b0;
    modelClear();
    expQ.push_back(5'b0);
    #1;
    got  = {stall, fwd_rs, fwd_rt};
    want = expQ.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL async_reset got %b want %b", got, want); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expQ.push_back(5'b0);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL no_stale_hazard got %b want %b", got, want); end
    tick();
  endtask

  task automatic test_load_use();
    logic [4:0] got, want;
    drain();
    present(1, 5'd8, 2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    present(1, 5'd9, 1, 5'd8, 1, 1, 5'd8, 1, 1, 0);
    expQ.push_back(5'b1_00_00);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL load_use_stall got %b want %b", got, want); end
    tick();
    expQ.push_back(5'b0_00_00);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL load_use_release got %b want %b", got, want); end
    tick();
    present(0, 0, 0, 5'd8, 1, 1, 5'd8, 1, 1, 0);
    expQ.push_back(5'b0_11_11);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL load_use_fwd_w got %b want %b", got, want); end
    tick();
  endtask

  task automatic test_branch();
    logic [4:0] got, want;
    drain();
    present(1, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    present(0, 0, 0, 5'd8, 1, 0, 5'd0, 1, 0, 0);
    expQ.push_back(5'b1_00_00);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL branch_stall got %b want %b", got, want); end
    tick();
    expQ.push_back(5'b0_10_00);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL branch_fwd_m got %b want %b", got, want); end
    tick();
    drain();
    present(1, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    present(1, 5'd8, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0);
    expQ.push_back(5'b0);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL chain_addu got %b want %b", got, want); end
    tick();
    present(0, 0, 0, 5'd0, 1, 1, 5'd8, 1, 2, 0);
    expQ.push_back(5'b0_00_01);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL chain_sw_fwd_e got %b want %b", got, want); end
    tick();
  endtask

  task automatic test_zero_reg();
    logic [4:0] got, want;
    drain();
    present(1, 5'd0, 2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    present(0, 0, 0, 5'd0, 1, 0, 5'd0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      expQ.push_back(5'b0);
      sample(got, want);
      checks++;
      if (got !== want) begin errors++; $display("[TB] FAIL zero_reg got %b want %b", got, want); end
      tick();
    end
  endtask

  task automatic test_flush_bubble();
    logic [4:0] got, want;
    drain();
    present(1, 5'd8, 2, 0, 0, 0, 0, 0, 0, 1);
    tick();
    present(0, 0, 0, 5'd8, 1, 0, 5'd8, 1, 0, 0);
    expQ.push_back(5'b0);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL flushed_write got %b want %b", got, want); end
    tick();
    drain();
    present(1, 5'd8, 2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    present(1, 5'd9, 2, 5'd8, 1, 0, 0, 0, 0, 0);
    expQ.push_back(5'b1_00_00);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL bubble_stall got %b want %b", got, want); end
    tick();
    present(0, 0, 0, 5'd9, 1, 0, 0, 0, 0, 0);
    expQ.push_back(5'b0);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL stalled_write_dropped got %b want %b", got, want); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, want;
    drain();
    present(1, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    present(1, 5'd8, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    present(0, 0, 0, 5'd8, 1, 0, 5'd8, 1, 0, 0);
    expQ.push_back(5'b0_01_01);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL youngest_fwd got %b want %b", got, want); end
    tick();
    drain();
    present(1, 5'd8, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    present(1, 5'd8, 2, 0, 0, 0, 0, 0, 0, 0); tick();
    present(0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0);
    expQ.push_back(5'b1_00_00);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL youngest_stall got %b want %b", got, want); end
    tick();
  endtask

`ifdef HZD_MDU_EN
  task automatic test_mdu();
    logic [4:0] got, want;
    drain();
    present(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    md_busy = 1'b1; d_is_md = 1'b1;
    expQ.push_back(5'b1_00_00);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL md_busy_stall got %b want %b", got, want); end
    tick();
    d_is_md = 1'b0;
    expQ.push_back(5'b0);
    sample(got, want);
    checks++;
    if (got !== want) begin errors++; $display("[TB] FAIL md_busy_non_md got %b want %b", got, want); end
    tick();
    md_busy = 1'b0; d_is_md = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expQ.push_back((i == 1) ? 5'b1_00_00 : 5'b0);
      sample(got, want);
      checks++;
      if (got !== want) begin errors++; $display("[TB] FAIL md_shadow[%0d] got %b want %b", i, got, want); end
      tick();
    end
    d_is_md = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [4:0] got, want;
    logic [4:0] regs[4];
    regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd10;
    drain();
    for (int i = 0; i < 120; i++) begin
      present($urandom_range(0, 1) == 1, regs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)),
              regs[$urandom_range(0, 3)], $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
              regs[$urandom_range(0, 3)], $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
              $urandom_range(0, 7) == 0);
`ifdef HZD_MDU_EN
      md_busy = ($urandom_range(0, 3) == 0);
      d_is_md = ($urandom_range(0, 2) == 0);
`endif
      expQ.push_back(modelEval());
      sample(got, want);
      checks++;
      if (got !== want) begin errors++; $display("[TB] FAIL random[%0d] got %b want %b", i, got, want); end
      tick();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_zero_reg();
    test_flush_bubble();
    test_back_to_back();
`ifdef HZD_MDU_EN
    test_mdu();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
